// File: rtl/act_pwl_unit.sv
// act_pwl_unit: piecewise-linear activation y = A*x + B in Q4.12, 3-stage stall-able valid/ready pipeline
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_x/in_func input handshake;
//        out_valid/out_ready/out_y result handshake; lut_we/lut_waddr/lut_wdata host LUT write port.
// Macro ACT_SAT_EN: clamp the result to the Q4.12 range; undefined, the result wraps.
module act_pwl_unit #(
  parameter int Q_INT         = 4,
  parameter int Q_FRAC        = 12,
  parameter int ACT_MASK_SIZE = 2,
  parameter int ACT_LUT_DEPTH = 6,
  parameter int ACT_LUT_SIZE  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [Q_INT+Q_FRAC-1:0]  in_x,
  input  logic [ACT_MASK_SIZE-1:0] in_func,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [Q_INT+Q_FRAC-1:0]  out_y,
  input  logic                     lut_we,
  input  logic [ACT_LUT_DEPTH-1:0] lut_waddr,
  input  logic [ACT_LUT_SIZE-1:0]  lut_wdata
);
  localparam int DW = Q_INT + Q_FRAC;
  localparam int PW = 2 * DW;
  localparam int SW = PW - Q_FRAC + 1;
  logic [ACT_LUT_SIZE-1:0] lut_mem [2**ACT_LUT_DEPTH];
  logic                    adv;
  logic [ACT_LUT_DEPTH-1:0] raddr;
  logic                    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [DW-1:0]           x1_q, x1_d, b2_q, b2_d, y3_q, y3_d, y_s3;
  logic [ACT_LUT_SIZE-1:0] lut_rd_q, lut_rd_d;
  logic [PW-1:0]           p2_q, p2_d, a_ext, x_ext, rnd_sum;
  logic [SW-1:0]           s;
  logic                    unused_bits;
  always_ff @(posedge clk)
    if (lut_we) lut_mem[lut_waddr] <= lut_wdata;
  assign adv       = ~(v3_q & ~out_ready);
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign out_y     = y3_q;
  assign raddr     = {in_func, in_x[DW-1 -: Q_INT]};
  // Low PW bits of an unsigned product of sign-extended operands equal the signed product
  assign a_ext     = {{DW{lut_rd_q[ACT_LUT_SIZE-1]}}, lut_rd_q[ACT_LUT_SIZE-1 -: DW]};
  assign x_ext     = {{DW{x1_q[DW-1]}}, x1_q};
  // Adding half an LSB before the arithmetic shift gives round-half-up
  assign rnd_sum   = p2_q + (PW'(1) << (Q_FRAC - 1));
  assign s         = {rnd_sum[PW-1], rnd_sum[PW-1:Q_FRAC]} + {{(SW-DW){b2_q[DW-1]}}, b2_q};
`ifdef ACT_SAT_EN
  // In range exactly when bits [SW-1:DW-1] all equal the sign
  assign y_s3 = (~s[SW-1] & |s[SW-2:DW-1]) ? {1'b0, {(DW-1){1'b1}}} :
                (s[SW-1] & ~&s[SW-2:DW-1]) ? {1'b1, {(DW-1){1'b0}}} : s[DW-1:0];
  assign unused_bits = ^rnd_sum[Q_FRAC-1:0];
`else
  assign y_s3 = s[DW-1:0];
  assign unused_bits = ^{rnd_sum[Q_FRAC-1:0], s[SW-1:DW]};
`endif
  always_comb begin
    v1_d     = adv ? in_valid : v1_q;
    x1_d     = adv ? in_x : x1_q;
    lut_rd_d = adv ? lut_mem[raddr] : lut_rd_q;
    v2_d     = adv ? v1_q : v2_q;
    p2_d     = adv ? a_ext * x_ext : p2_q;
    b2_d     = adv ? lut_rd_q[DW-1:0] : b2_q;
    v3_d     = adv ? v2_q : v3_q;
    y3_d     = adv ? y_s3 : y3_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1_q     <= 1'b0;
      x1_q     <= '0;
      lut_rd_q <= '0;
      v2_q     <= 1'b0;
      p2_q     <= '0;
      b2_q     <= '0;
      v3_q     <= 1'b0;
      y3_q     <= '0;
    end else begin
      v1_q     <= v1_d;
      x1_q     <= x1_d;
      lut_rd_q <= lut_rd_d;
      v2_q     <= v2_d;
      p2_q     <= p2_d;
      b2_q     <= b2_d;
      v3_q     <= v3_d;
      y3_q     <= y3_d;
    end
endmodule
